// File: rtl/fft_8p_frame_ctrl_if.sv
// fft_8p_frame_ctrl_if: sample-in and bin-out valid/ready streams of the FFT frame controller
interface fft_8p_frame_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int N = 8
);
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_real;
  logic [DATA_WIDTH-1:0] s_imag;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_real;
  logic [DATA_WIDTH-1:0] m_imag;
  logic [$clog2(N)-1:0]  m_index;
  logic                  m_last;
  modport master (
    output s_valid, s_real, s_imag, m_ready,
    input  s_ready, m_valid, m_real, m_imag, m_index, m_last
  );
  modport slave (
    input  s_valid, s_real, s_imag, m_ready,
    output s_ready, m_valid, m_real, m_imag, m_index, m_last
  );
endinterface

// File: rtl/fft_8p_frame_ctrl.sv
// fft_8p_frame_ctrl: fills an N-sample frame, holds fft_start until done, streams the bins; FFT_CTRL_SCALE_EN scales bins by 1/N
module fft_8p_frame_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int N = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    arst_n,
  input  logic                    flush,
  fft_8p_frame_ctrl_if.slave      st,
  output logic                    fft_start,
  input  logic                    fft_done,
  output logic [N*DATA_WIDTH-1:0] fft_x_real,
  output logic [N*DATA_WIDTH-1:0] fft_x_imag,
  input  logic [N*DATA_WIDTH-1:0] fft_X_real,
  input  logic [N*DATA_WIDTH-1:0] fft_X_imag,
  output logic                    busy,
  output logic                    timeout_err
);
  localparam int CW = $clog2(N);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {FILL, RUN, DRAIN} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [TW-1:0] tcnt;
  logic [DATA_WIDTH-1:0] x_re [N];
  logic [DATA_WIDTH-1:0] x_im [N];
  logic [DATA_WIDTH-1:0] b_re [N];
  logic [DATA_WIDTH-1:0] b_im [N];
  logic s_hs, m_hs, cap, last;
  always_comb begin
    s_hs = state == FILL && st.s_valid && !flush;
    m_hs = state == DRAIN && st.m_ready && !flush;
    last = cnt == CW'(N - 1);
    cap = state == RUN && fft_done && !flush;
    timeout_err = state == RUN && !fft_done && !flush && tcnt == TW'(TIMEOUT_CYCLES - 1);
    state_n = state;
    cnt_n = cnt;
    if (flush) begin
      state_n = FILL;
      cnt_n = '0;
    end else if (s_hs || m_hs) begin
      cnt_n = cnt + 1'b1;
      state_n = last ? (s_hs ? RUN : FILL) : state;
    end else if (cap) state_n = DRAIN;
    else if (timeout_err) state_n = FILL;
  end
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state <= FILL;
      cnt <= '0;
      tcnt <= '0;
      fft_start <= 1'b0;
      for (int k = 0; k < N; k++) begin
        x_re[k] <= '0;
        x_im[k] <= '0;
        b_re[k] <= '0;
        b_im[k] <= '0;
      end
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      tcnt <= (state == RUN && state_n == RUN) ? tcnt + 1'b1 : '0;
      fft_start <= state_n == RUN;
      if (s_hs) begin
        x_re[cnt] <= st.s_real;
        x_im[cnt] <= st.s_imag;
      end
      if (cap)
        for (int k = 0; k < N; k++) begin
`ifdef FFT_CTRL_SCALE_EN
          b_re[k] <= $signed(fft_X_real[k*DATA_WIDTH +: DATA_WIDTH]) >>> CW;
          b_im[k] <= $signed(fft_X_imag[k*DATA_WIDTH +: DATA_WIDTH]) >>> CW;
`else
          b_re[k] <= fft_X_real[k*DATA_WIDTH +: DATA_WIDTH];
          b_im[k] <= fft_X_imag[k*DATA_WIDTH +: DATA_WIDTH];
`endif
        end
    end
  end
  for (genvar g = 0; g < N; g++) begin : g_pack
    assign fft_x_real[g*DATA_WIDTH +: DATA_WIDTH] = x_re[g];
    assign fft_x_imag[g*DATA_WIDTH +: DATA_WIDTH] = x_im[g];
  end
  assign st.s_ready = state == FILL;
  assign st.m_valid = state == DRAIN;
  assign st.m_last = state == DRAIN && last;
  assign st.m_index = state == DRAIN ? cnt : '0;
  assign st.m_real = state == DRAIN ? b_re[cnt] : '0;
  assign st.m_imag = state == DRAIN ? b_im[cnt] : '0;
  assign busy = state != FILL || cnt != '0;
endmodule
